// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial tap masks, legal-order check and
// the checker state encoding.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } chk_st_e;

  function automatic logic order_ok(input int order);
    return (order == 7) || (order == 9) || (order == 15) ||
           (order == 23) || (order == 31);
  endfunction

  // Taps are 0-based state bits; the x^ORDER term is always the MSB.
  function automatic logic [31:0] tap_mask(input int order);
    case (order)
      7:       return 32'h0000_0060;
      9:       return 32'h0000_0110;
      15:      return 32'h0000_6000;
      23:      return 32'h0042_0000;
      31:      return 32'h4800_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR; shifts either its own feedback or a serial input bit
// into bit 0, and exposes the MSB and the predicted feedback bit.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int ORDER    = 7,
  parameter bit RST_ONES = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic shift_i,
  input  logic load_i,
  input  logic ser_i,
  output logic msb_o,
  output logic fb_o
);

  localparam logic [31:0] TAPS32 = tap_mask(ORDER);
  localparam logic [ORDER-1:0] TAPS = TAPS32[ORDER-1:0];

  logic [ORDER-1:0] lfsr_q, lfsr_d;

  assign fb_o   = ^(lfsr_q & TAPS);
  assign msb_o  = lfsr_q[ORDER-1];
  assign lfsr_d = {lfsr_q[ORDER-2:0], load_i ? ser_i : fb_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      lfsr_q <= RST_ONES ? '1 : '0;
    else if (shift_i) lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/prbs_bert.sv
// PRBS generator plus self-synchronising checker with loss-of-lock window
// and saturating error/bit counters.
module prbs_bert
  import prbs_pkg::*;
#(
  parameter int ORDER       = 7,
  parameter int CNT_W       = 32,
  parameter int SYNC_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             bit_en,
  input  logic             gen_en,
  input  logic             invert,
  output logic             gen_out,
  input  logic             chk_en,
  input  logic             chk_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow
);

  if (!order_ok(ORDER)) begin : g_bad_order
    $error("prbs_bert: unsupported ORDER %0d", ORDER);
  end
  if (WINDOW < 2) begin : g_bad_window
    $error("prbs_bert: WINDOW must be >= 2, got %0d", WINDOW);
  end

  localparam int LD_W  = $clog2(ORDER + 1);
  localparam int MT_W  = $clog2(SYNC_THRESH + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int WE_W  = $clog2(LOSS_THRESH + 2);
  localparam int LT_M1 = (LOSS_THRESH > 0) ? LOSS_THRESH - 1 : 0;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic gen_adv, chk_adv, gen_msb, chk_fb, rx_bit, miss, loss;
  logic unused_gen_fb, unused_chk_msb;

  chk_st_e          st_q;
  logic [LD_W-1:0]  ld_q;
  logic [MT_W-1:0]  mt_q;
  logic [WIN_W-1:0] win_q;
  logic [WE_W-1:0]  werr_q;
  logic             locked_q, vld_q, miss_q, gen_out_q, err_flag_q, ovf_q;
  logic [CNT_W-1:0] err_cnt_q, bit_cnt_q;

  assign gen_adv = bit_en & gen_en;
  assign chk_adv = bit_en & chk_en;
  assign rx_bit  = chk_in ^ invert;
  assign miss    = rx_bit ^ chk_fb;
  assign loss    = (LOSS_THRESH != 0) && miss && (werr_q == WE_W'(LT_M1));

  prbs_lfsr #(.ORDER(ORDER), .RST_ONES(1'b1)) u_gen (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .shift_i(gen_adv), .load_i(1'b0),
    .ser_i(1'b0), .msb_o(gen_msb), .fb_o(unused_gen_fb)
  );

  // Loads received bits until locked, then free-runs on its own prediction.
  prbs_lfsr #(.ORDER(ORDER), .RST_ONES(1'b0)) u_chk (
    .clk_i(sys_clk), .rst_ni(sys_rst_n), .shift_i(chk_adv),
    .load_i(st_q != ST_LOCKED), .ser_i(rx_bit),
    .msb_o(unused_chk_msb), .fb_o(chk_fb)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   gen_out_q <= 1'b0;
    else if (gen_adv) gen_out_q <= gen_msb ^ invert;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q     <= ST_SEARCH;
      ld_q     <= '0;
      mt_q     <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      vld_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      miss_q <= 1'b0;
      if (chk_adv) begin
        case (st_q)
          ST_SEARCH: begin
            if (ld_q == LD_W'(ORDER - 1)) begin
              st_q <= ST_VERIFY;
              ld_q <= '0;
            end else begin
              ld_q <= ld_q + 1'b1;
            end
          end
          ST_VERIFY: begin
            if (miss) begin
              st_q <= ST_SEARCH;
              ld_q <= '0;
              mt_q <= '0;
            end else if (mt_q == MT_W'(SYNC_THRESH - 1)) begin
              st_q     <= ST_LOCKED;
              locked_q <= 1'b1;
              mt_q     <= '0;
              win_q    <= '0;
              werr_q   <= '0;
            end else begin
              mt_q <= mt_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            vld_q  <= 1'b1;
            miss_q <= miss;
            // Loss outranks the window wrap when both land on the same bit.
            if (loss) begin
              st_q     <= ST_SEARCH;
              locked_q <= 1'b0;
              win_q    <= '0;
              werr_q   <= '0;
            end else if (win_q == WIN_W'(WINDOW - 1)) begin
              win_q  <= '0;
              werr_q <= '0;
            end else begin
              win_q  <= win_q + 1'b1;
              werr_q <= werr_q + WE_W'(miss);
            end
          end
          default: st_q <= ST_SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      err_flag_q <= vld_q & miss_q;
      if (clear) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else if (vld_q) begin
        if (bit_cnt_q != CMAX) bit_cnt_q <= bit_cnt_q + 1'b1;
        if (miss_q && (err_cnt_q != CMAX)) err_cnt_q <= err_cnt_q + 1'b1;
        if ((bit_cnt_q == CMAX - 1'b1) || (miss_q && (err_cnt_q == CMAX - 1'b1)))
          ovf_q <= 1'b1;
      end
    end
  end

  assign gen_out  = gen_out_q;
  assign locked   = locked_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_prbs_bert.sv
// Bench for prbs_bert: default instance in loopback (a) plus a narrow-counter,
// no-loss instance (b); gen_out and checker results go through a scoreboard.
module tb_prbs_bert;

  logic sys_clk = 1'b0;
  logic sys_rst_n, bit_en, gen_en, chk_en, invert, clear, flip_a, flip_b;
  logic gen_out_a, locked_a, err_flag_a, overflow_a, chk_in_a;
  logic gen_out_b, locked_b, err_flag_b, overflow_b, chk_in_b;
  logic [31:0] err_cnt_a, bit_cnt_a;
  logic [3:0]  err_cnt_b, bit_cnt_b;

  assign chk_in_a = gen_out_a ^ flip_a;
  assign chk_in_b = gen_out_b ^ flip_b;

  always #5 sys_clk = ~sys_clk;

  prbs_bert u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bit_en(bit_en), .gen_en(gen_en),
    .invert(invert), .gen_out(gen_out_a), .chk_en(chk_en), .chk_in(chk_in_a),
    .clear(clear), .locked(locked_a), .err_flag(err_flag_a), .err_cnt(err_cnt_a),
    .bit_cnt(bit_cnt_a), .overflow(overflow_a)
  );

  prbs_bert #(.CNT_W(4), .LOSS_THRESH(0)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bit_en(bit_en), .gen_en(gen_en),
    .invert(invert), .gen_out(gen_out_b), .chk_en(chk_en), .chk_in(chk_in_b),
    .clear(clear), .locked(locked_b), .err_flag(err_flag_b), .err_cnt(err_cnt_b),
    .bit_cnt(bit_cnt_b), .overflow(overflow_b)
  );

  typedef struct {
    int          due;
    logic        ef;
    logic [31:0] ec;
    logic [31:0] bc;
  } sb_t;

  int  n_chk = 0, n_err = 0, cyc_n = 0, ngen = 0, ef_cnt = 0;
  int  m_acq, m_wbits, m_werr;
  logic [31:0] m_ec, m_bc;
  bit  m_locked, mdl_on = 1'b0, last_g = 1'b0;
  bit  sq[$];
  bit  gq[$];
  sb_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic mdl_rst();
    m_locked = 1'b0; m_acq = 0; m_wbits = 0; m_werr = 0; m_ec = '0; m_bc = '0;
    sbq.delete();
  endtask

  // One clock: push expectations for the inputs now driven, then compare
  // everything that falls due at the following negedge.
  task automatic cyc();
    bit  b;
    sb_t it;
    if (bit_en && gen_en) begin
      b = (ngen < 7) ? 1'b1 : (sq[ngen-7] ^ sq[ngen-6]);
      sq.push_back(b);
      ngen++;
      gq.push_back(b ^ invert);
    end
    if (clear) begin
      foreach (sbq[i]) if (sbq[i].due == cyc_n) begin sbq[i].ec = '0; sbq[i].bc = '0; end
      m_ec = '0; m_bc = '0;
    end
    if (mdl_on && bit_en && chk_en) begin
      it.due = cyc_n + 1;
      it.ef  = 1'b0;
      if (!m_locked) begin
        m_acq++;
        if (m_acq == 23) begin m_locked = 1'b1; m_wbits = 0; m_werr = 0; end
      end else begin
        m_bc++;
        it.ef = flip_a;
        if (flip_a) begin m_ec++; m_werr++; end
        if (flip_a && m_werr == 4) begin m_locked = 1'b0; m_acq = 0; end
        else if (m_wbits == 63) begin m_wbits = 0; m_werr = 0; end
        else m_wbits++;
      end
      it.ec = m_ec;
      it.bc = m_bc;
      sbq.push_back(it);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    while (gq.size() > 0) begin
      last_g = gq.pop_front();
      chk("gen_out", gen_out_a, last_g);
    end
    while (sbq.size() > 0 && sbq[0].due == cyc_n) begin
      it = sbq.pop_front();
      chk("err_flag", err_flag_a, it.ef);
      chk("err_cnt", err_cnt_a, it.ec);
      chk("bit_cnt", bit_cnt_a, it.bc);
    end
    if (mdl_on) chk("locked", locked_a, m_locked);
    if (err_flag_a === 1'b1) ef_cnt++;
    cyc_n++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1);
  end

  initial begin
    bit obs[$];
    int ones, rep, g;
    sys_rst_n = 1'b0; bit_en = 1'b0; gen_en = 1'b0; chk_en = 1'b0;
    invert = 1'b0; clear = 1'b0; flip_a = 1'b0; flip_b = 1'b0;
    mdl_rst();
    repeat (2) @(negedge sys_clk);
    chk("rst_gen_out", gen_out_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_err_flag", err_flag_a, 0);
    chk("rst_err_cnt", err_cnt_a, 0);
    chk("rst_bit_cnt", bit_cnt_a, 0);
    chk("rst_overflow", overflow_a, 0);
    chk("rst_gen_lfsr", u_a.u_gen.lfsr_q, 7'h7f);
    chk("rst_chk_lfsr", u_a.u_chk.lfsr_q, 7'h00);
    sys_rst_n = 1'b1;

    // Period: two full periods of the generator
    bit_en = 1'b1; gen_en = 1'b1;
    for (int i = 0; i < 254; i++) begin cyc(); obs.push_back(gen_out_a); end
    ones = 0; rep = 0;
    for (int i = 0; i < 127; i++) begin
      if (obs[i]) ones++;
      if (obs[i] != obs[i+127]) rep++;
    end
    chk("period_ones", ones, 64);
    chk("period_zeros", 127 - ones, 63);
    chk("period_repeat", rep, 0);

    invert = 1'b1; repeat (20) cyc();
    invert = 1'b0; repeat (10) cyc();
    bit_en = 1'b0; repeat (3) cyc();
    chk("gen_hold", gen_out_a, last_g);

    // Loopback lock
    bit_en = 1'b1; chk_en = 1'b1; mdl_rst(); mdl_on = 1'b1;
    repeat (22) cyc();
    chk("lock_pre23", locked_a, 0);
    cyc();
    chk("lock_at23", locked_a, 1);
    chk("lock_at23_b", locked_b, 1);
    repeat (1000) cyc();
    bit_en = 1'b0; cyc();
    chk("loop_bit_cnt", bit_cnt_a, 1000);
    chk("loop_err_cnt", err_cnt_a, 0);
    repeat (2) cyc();
    chk("hold_bit_cnt", bit_cnt_a, 1000);
    chk("b_bitcnt_sat", bit_cnt_b, 15);
    chk("b_ovf_bitcnt", overflow_b, 1);

    // Single-bit error
    bit_en = 1'b1; repeat (5) cyc();
    ef_cnt = 0;
    flip_a = 1'b1; cyc(); flip_a = 1'b0;
    repeat (5) cyc();
    chk("single_pulses", ef_cnt, 1);
    chk("single_err_cnt", err_cnt_a, 1);
    chk("single_locked", locked_a, 1);

    // Burst of 4 errors in 10 bits, the 4th landing on the window wrap bit
    g = 0;
    while (m_wbits != 0 && g < 100) begin cyc(); g++; end
    g = 0;
    while (m_wbits != 54 && g < 100) begin cyc(); g++; end
    for (int k = 0; k < 10; k++) begin
      flip_a = (k % 3 == 0);
      cyc();
      if (k == 8) chk("burst_still_locked", locked_a, 1);
    end
    flip_a = 1'b0;
    chk("burst_loss", locked_a, 0);
    repeat (22) cyc();
    chk("relock_pre", locked_a, 0);
    cyc();
    chk("relock", locked_a, 1);
    bit_en = 1'b0; cyc();
    chk("relock_err_kept", err_cnt_a, 5);
    bit_en = 1'b1;

    // Saturation and clear on the 4-bit instance
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clr_b_err", err_cnt_b, 0);
    chk("clr_b_bit", bit_cnt_b, 0);
    chk("clr_b_ovf", overflow_b, 0);
    flip_b = 1'b1; repeat (20) cyc();
    chk("sat_b_err", err_cnt_b, 15);
    chk("sat_b_ovf", overflow_b, 1);
    chk("sat_b_locked", locked_b, 1);
    clear = 1'b1; cyc(); clear = 1'b0; flip_b = 1'b0;
    chk("clrhit_b_err", err_cnt_b, 0);
    chk("clrhit_b_ovf", overflow_b, 0);
    repeat (3) cyc();
    chk("post_clr_b_err", err_cnt_b, 1);

    // Asynchronous reset while locked
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_gen_out", gen_out_a, 0);
    chk("arst_locked", locked_a, 0);
    chk("arst_err_flag", err_flag_a, 0);
    chk("arst_bit_cnt", bit_cnt_a, 0);
    chk("arst_b_err", err_cnt_b, 0);
    chk("arst_b_ovf", overflow_b, 0);
    chk("arst_gen_lfsr", u_a.u_gen.lfsr_q, 7'h7f);
    @(posedge sys_clk); @(negedge sys_clk);
    chk("arst_hold_locked", locked_a, 0);
    sq.delete(); gq.delete(); ngen = 0; mdl_rst();
    sys_rst_n = 1'b1;
    repeat (22) cyc();
    chk("rst_relock_pre", locked_a, 0);
    cyc();
    chk("rst_relock", locked_a, 1);
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_bert.md
PRBS_BERT -- requirements
Module: prbs_bert

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  ORDER  7  LFSR order; legal values 7, 9, 15, 23, 31; any other value is an elaboration error.
  CNT_W  32  width of err_cnt and bit_cnt.
  SYNC_THRESH  16  consecutive matched bits needed to declare lock.
  LOSS_THRESH  4  errors within one window that force loss of lock; 0 disables loss detection.
  WINDOW  64  loss-detection window length in bits; must be ≥ 2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  sys_clk  in  1  single clock.
  sys_rst_n  in  1  reset; asynchronous, active-low.
  bit_en  in  1  data-rate strobe; generator and checker advance only on cycles where it is 1.
  gen_en  in  1  generator enable, qualified by bit_en.
  invert  in  1  inverts gen_out and the expected checker polarity; static while locked.
  gen_out  out  1  registered PRBS output bit.
  chk_en  in  1  checker enable, qualified by bit_en.
  chk_in  in  1  received bit under test.
  clear  in  1  synchronous clear of the counters.
  locked  out  1  checker is in LOCKED.
  err_flag  out  1  one-cycle pulse per detected bit error.
  err_cnt  out  CNT_W  saturating count of bit errors.
  bit_cnt  out  CNT_W  saturating count of bits checked while locked.
  overflow  out  1  sticky; set when either counter saturates.

Function
REQ-003 The generator SHALL be a Fibonacci LFSR using the primitive polynomial for ORDER (7:x^7+x^6+1, 9:x^9+x^5+1, 15:x^15+x^14+1, 23:x^23+x^18+1, 31:x^31+x^28+1), with a period of 2^ORDER−1.
REQ-004 On each cycle where bit_en=1 and gen_en=1, the generator SHALL shift once, and gen_out SHALL take the value MSB XOR invert on that edge.
REQ-005 The checker FSM SHALL have the states SEARCH, VERIFY and LOCKED, and SHALL advance only on cycles where bit_en=1 and chk_en=1.
REQ-006 In SEARCH, the checker SHALL shift (chk_in XOR invert) into its LFSR, and SHALL move to VERIFY after ORDER consecutive shifts.
REQ-007 In VERIFY, the checker SHALL compare each received bit with the predicted feedback bit. On a match it SHALL shift the received bit in and increment the match counter. On a mismatch it SHALL return to SEARCH and clear both the load counter and the match counter.
REQ-008 VERIFY SHALL move to LOCKED on the SYNC_THRESH-th consecutive match.
REQ-009 In LOCKED, the checker LFSR SHALL free-run on its own predicted bit. Each compared bit SHALL increment bit_cnt, and each mismatch SHALL increment err_cnt and pulse err_flag.
REQ-010 err_flag, err_cnt and bit_cnt SHALL update one sys_clk cycle after the sampling edge.
REQ-011 The loss window counter SHALL wrap every WINDOW compared bits, and the window error count SHALL be cleared at each wrap.
REQ-012 When the window error count reaches LOSS_THRESH (and LOSS_THRESH ≠ 0), the FSM SHALL return to SEARCH and locked SHALL drop on that same edge. If the reaching error falls on the wrap bit, loss SHALL take priority.
REQ-013 err_cnt and bit_cnt SHALL saturate at 2^CNT_W−1, and overflow SHALL set on the saturating edge and remain set until clear or reset.
REQ-014 clear SHALL zero err_cnt, bit_cnt and overflow. If clear coincides with an increment, clear SHALL win and the result SHALL be 0.
REQ-015 clear SHALL NOT affect the FSM state, locked, the window counters or either LFSR.
REQ-016 Counters SHALL hold their values while bit_en=0 or chk_en=0.

Reset
REQ-017 While sys_rst_n=0, the generator LFSR SHALL be all ones and the checker LFSR all zeros.
REQ-018 While sys_rst_n=0, the FSM SHALL be in SEARCH, and gen_out, locked, err_flag, err_cnt, bit_cnt and overflow SHALL all be 0.
REQ-019 Reset asserted mid-operation SHALL abort any lock immediately (asynchronously), and the first bit_en after reset release SHALL be treated as SEARCH bit 0.

Structure
REQ-020 Shared package prbs_pkg SHALL hold the per-ORDER tap-mask function, the legal-ORDER check and the checker state enum.
REQ-021 A single sub-module, prbs_lfsr (parameters ORDER; ports for shift, load-bit select and serial in), SHALL be instantiated twice: once for the generator and once for the checker.

Verification
REQ-022 The bench SHALL cover these scenarios:
  Period check: ORDER=7, bit_en every cycle, gen_en=1 → sequence repeats after 127 bits, with 64 ones and 63 zeros per period.
  Loopback lock: gen_out→chk_in → locked rises on the 23rd checked bit (7+16); after 1000 further bits, err_cnt=0 and bit_cnt=1000.
  Single-bit error: one bit flipped after lock → one err_flag pulse, err_cnt=1, locked stays 1.
  Burst loss: LOSS_THRESH=4, WINDOW=64, 4 bits flipped within 10 bits → locked drops on the 4th error; relock 23 bits later with counters preserved.
  Saturation and clear: CNT_W=4, LOSS_THRESH=0, invert mismatched for 20 bits → err_cnt=15, overflow=1; clear coincident with an error → err_cnt=0, overflow=0.
  Reset mid-lock: sys_rst_n pulsed low while locked → all outputs 0 within the reset cycle, gen LFSR all ones; relock after 23 bits.
